// File: rtl/nmcu_mem_arbiter_if.sv
// Requester-side and memory-side signal bundle of the NMCU memory arbiter.
// The arbiter connects through 'slave'; requesters and memory model connect through 'master'.
interface nmcu_mem_arbiter_if #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned DATABUS_WIDTH = 32
);
  logic [NUM_REQ-1:0]       req_sel;
  logic [NUM_REQ-1:0]       req_w;
  logic [ADDR_WIDTH-1:0]    req_addr  [NUM_REQ];
  logic [DATABUS_WIDTH-1:0] req_wdata [NUM_REQ];
  logic [NUM_REQ-1:0]       req_ack;
  logic [NUM_REQ-1:0]       req_err;
  logic [DATABUS_WIDTH-1:0] rdata;
  logic                     mem_sel;
  logic                     mem_w;
  logic [ADDR_WIDTH-1:0]    mem_addr;
  logic [DATABUS_WIDTH-1:0] mem_wdata;
  logic                     mem_ready;
  logic [DATABUS_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_sel, req_w, req_addr, req_wdata, mem_ready, mem_rdata,
    output req_ack, req_err, rdata, mem_sel, mem_w, mem_addr, mem_wdata
  );

  modport master (
    output req_sel, req_w, req_addr, req_wdata, mem_ready, mem_rdata,
    input  req_ack, req_err, rdata, mem_sel, mem_w, mem_addr, mem_wdata
  );
endinterface

// File: rtl/nmcu_mem_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ requesters.
// Each grant runs IDLE -> ISSUE -> RELEASE, and ISSUE is bounded by a timeout.
module nmcu_mem_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned DATABUS_WIDTH = 32,
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  nmcu_mem_arbiter_if.slave          bus,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       err_sticky
);

  localparam int unsigned IDW  = $clog2(NUM_REQ);
  localparam int unsigned CNTW = $clog2(TIMEOUT);
  localparam logic [IDW-1:0]  LAST_ID   = IDW'(NUM_REQ - 1);
  localparam logic [CNTW-1:0] CNT_LIMIT = CNTW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [IDW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]           grant_id_q, grant_id_d;
  logic [CNTW-1:0]          cnt_q, cnt_d;
  logic                     mem_sel_q, mem_sel_d;
  logic                     mem_w_q, mem_w_d;
  logic [ADDR_WIDTH-1:0]    mem_addr_q, mem_addr_d;
  logic [DATABUS_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [NUM_REQ-1:0]       req_ack_q, req_ack_d;
  logic [NUM_REQ-1:0]       req_err_q, req_err_d;
  logic [DATABUS_WIDTH-1:0] rdata_q, rdata_d;
  logic                     busy_q, busy_d;
  logic                     err_sticky_q, err_sticky_d;

  logic                     found_c;
  logic [IDW-1:0]           winner_c;
  logic [IDW-1:0]           cand_c;
  logic                     done_c;

  // First requester at or above rr_ptr, wrapping with an explicit modulo so
  // non-power-of-two NUM_REQ never yields an index past NUM_REQ-1.
  always_comb begin
    found_c  = 1'b0;
    winner_c = '0;
    cand_c   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_c = IDW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!found_c && bus.req_sel[cand_c]) begin
        found_c  = 1'b1;
        winner_c = cand_c;
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    cnt_d        = cnt_q;
    mem_sel_d    = mem_sel_q;
    mem_w_d      = mem_w_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    req_ack_d    = '0;
    req_err_d    = '0;
    rdata_d      = rdata_q;
    err_sticky_d = err_sticky_q;
    done_c       = 1'b0;

    case (state_q)
      IDLE: begin
        if (found_c) begin
          state_d     = ISSUE;
          grant_id_d  = winner_c;
          cnt_d       = '0;
          mem_sel_d   = 1'b1;
          mem_w_d     = bus.req_w[winner_c];
          mem_addr_d  = bus.req_addr[winner_c];
          mem_wdata_d = bus.req_wdata[winner_c];
        end
      end

      ISSUE: begin
        // Ready wins over a timeout landing on the same edge.
        if (bus.mem_ready) begin
          req_ack_d[grant_id_q] = 1'b1;
          if (!mem_w_q) begin
            rdata_d = bus.mem_rdata;
          end
          done_c = 1'b1;
        end else if (cnt_q == CNT_LIMIT) begin
          req_err_d[grant_id_q] = 1'b1;
          err_sticky_d          = 1'b1;
          done_c                = 1'b1;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end

        if (done_c) begin
          state_d   = RELEASE;
          mem_sel_d = 1'b0;
          mem_w_d   = 1'b0;
          rr_ptr_d  = (grant_id_q == LAST_ID) ? '0 : grant_id_q + IDW'(1);
        end
      end

      RELEASE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      cnt_q        <= '0;
      mem_sel_q    <= 1'b0;
      mem_w_q      <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      req_ack_q    <= '0;
      req_err_q    <= '0;
      rdata_q      <= '0;
      busy_q       <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      cnt_q        <= cnt_d;
      mem_sel_q    <= mem_sel_d;
      mem_w_q      <= mem_w_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      req_ack_q    <= req_ack_d;
      req_err_q    <= req_err_d;
      rdata_q      <= rdata_d;
      busy_q       <= busy_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign bus.req_ack   = req_ack_q;
  assign bus.req_err   = req_err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_sel   = mem_sel_q;
  assign bus.mem_w     = mem_w_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = busy_q;
  assign grant_id      = grant_id_q;
  assign err_sticky    = err_sticky_q;

endmodule

// File: tb/tb_nmcu_mem_arbiter.sv
// Randomized self-checking bench for nmcu_mem_arbiter, compared against a
// transaction-level model of grants, acks, timeouts and sticky error.
module tb_nmcu_mem_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          busy;
  logic [1:0]    grant_id;
  logic          err_sticky;

  nmcu_mem_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATABUS_WIDTH(DW)) bus ();

  nmcu_mem_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATABUS_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .busy      (busy),
    .grant_id  (grant_id),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  // Model: round-robin pointer, sticky error, last read data, requester payloads.
  int              m_rr;
  logic            m_sticky;
  logic [DW-1:0]   m_rdata;
  logic            m_w     [N];
  logic [AW-1:0]   m_addr  [N];
  logic [DW-1:0]   m_wdata [N];
  bit              perturb;
  int              last_win;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick_winner(input logic [N-1:0] sel, input int rr);
    for (int k = 0; k < int'(N); k++) begin
      if (sel[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  function automatic int rand_lat();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return int'($urandom_range(0, 3));
    if (r < 8) return int'($urandom_range(4, TO - 2));
    if (r == 8) return int'(TO) - 1;
    return int'(TO) + int'($urandom_range(0, 3));
  endfunction

  task automatic post_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_w[i]           = w;
    m_addr[i]        = a;
    m_wdata[i]       = d;
    bus.req_w[i]     = w;
    bus.req_addr[i]  = a;
    bus.req_wdata[i] = d;
    bus.req_sel[i]   = 1'b1;
  endtask

  task automatic post_rand(input int i);
    post_req(i, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
  endtask

  // Idle requesters scribble on their buses and may raise new requests mid-grant.
  task automatic perturb_idle_reqs();
    for (int i = 0; i < int'(N); i++) begin
      if (!bus.req_sel[i]) begin
        bus.req_addr[i]  = AW'($urandom);
        bus.req_wdata[i] = $urandom;
        bus.req_w[i]     = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) post_rand(i);
      end
    end
  endtask

  // Entered in an IDLE cycle before its closing edge; returns at the negedge of the next IDLE cycle.
  task automatic do_txn(input int lat, input logic [DW-1:0] rd_val, input bit rand_rd);
    int            w;
    int            n_iss;
    bit            acked;
    logic [DW-1:0] rd;
    logic [N-1:0]  e_ack;
    logic [N-1:0]  e_err;
    logic [AW-1:0] e_addr;
    logic          e_w;
    logic [DW-1:0] e_wd;

    if (bus.req_sel == '0) post_rand(0);
    w      = pick_winner(bus.req_sel, m_rr);
    e_addr = m_addr[w];
    e_w    = m_w[w];
    e_wd   = m_wdata[w];
    bus.mem_ready = 1'($urandom_range(0, 1));
    tick();

    acked = (lat + 1 <= int'(TO));
    n_iss = acked ? lat + 1 : int'(TO);
    rd    = '0;
    for (int k = 1; k <= n_iss; k++) begin
      rd = rand_rd ? $urandom : rd_val;
      bus.mem_ready = (k == lat + 1);
      bus.mem_rdata = rd;
      if (perturb) perturb_idle_reqs();
      @(negedge clk);
      check_eq("issue_sel",    bus.mem_sel, 1);
      check_eq("issue_gid",    grant_id, w);
      check_eq("issue_addr",   bus.mem_addr, e_addr);
      check_eq("issue_w",      bus.mem_w, e_w);
      check_eq("issue_wdata",  bus.mem_wdata, e_wd);
      check_eq("issue_ackerr", {bus.req_ack, bus.req_err}, 0);
      check_eq("issue_busy",   busy, 1);
      tick();
    end

    bus.mem_ready = 1'($urandom_range(0, 1));
    bus.mem_rdata = $urandom;
    e_ack = acked ? (N'(1) << w) : '0;
    e_err = acked ? '0 : (N'(1) << w);
    if (acked && !e_w) m_rdata = rd;
    if (!acked) m_sticky = 1'b1;
    m_rr     = (w + 1) % N;
    last_win = w;
    bus.req_sel[w] = 1'b0;
    @(negedge clk);
    check_eq("rel_ack",    bus.req_ack, e_ack);
    check_eq("rel_err",    bus.req_err, e_err);
    check_eq("rel_rdata",  bus.rdata, m_rdata);
    check_eq("rel_sel",    bus.mem_sel, 0);
    check_eq("rel_w",      bus.mem_w, 0);
    check_eq("rel_busy",   busy, 1);
    check_eq("rel_sticky", err_sticky, m_sticky);
    tick();
    @(negedge clk);
    check_eq("idle_ackerr", {bus.req_ack, bus.req_err}, 0);
    check_eq("idle_sel",    bus.mem_sel, 0);
    check_eq("idle_busy",   busy, 0);
    check_eq("idle_gid",    grant_id, w);
    check_eq("idle_rdata",  bus.rdata, m_rdata);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.req_sel   = '0;
    bus.req_w     = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    for (int i = 0; i < int'(N); i++) begin
      bus.req_addr[i]  = '0;
      bus.req_wdata[i] = '0;
      m_w[i]           = 1'b0;
      m_addr[i]        = '0;
      m_wdata[i]       = '0;
    end
    m_rr     = 0;
    m_sticky = 1'b0;
    m_rdata  = '0;
    perturb  = 1'b0;
    last_win = 0;

    // Reset values
    repeat (2) @(negedge clk);
    check_eq("rst_sel",    bus.mem_sel, 0);
    check_eq("rst_w",      bus.mem_w, 0);
    check_eq("rst_addr",   bus.mem_addr, 0);
    check_eq("rst_wdata",  bus.mem_wdata, 0);
    check_eq("rst_ackerr", {bus.req_ack, bus.req_err}, 0);
    check_eq("rst_rdata",  bus.rdata, 0);
    check_eq("rst_busy",   busy, 0);
    check_eq("rst_gid",    grant_id, 0);
    check_eq("rst_sticky", err_sticky, 0);
    rst_n = 1'b1;

    // No requests, stray mem_ready: stays idle
    bus.mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("noreq_sel",    bus.mem_sel, 0);
      check_eq("noreq_busy",   busy, 0);
      check_eq("noreq_ackerr", {bus.req_ack, bus.req_err}, 0);
    end

    // All four held, always ready: grants rotate 0,1,2,3,0
    for (int i = 0; i < int'(N); i++) post_rand(i);
    for (int j = 0; j < 5; j++) begin
      do_txn(0, '0, 1'b1);
      check_eq("rr_order", grant_id, j % N);
      post_rand(last_win);
    end
    bus.req_sel = '0;

    // Single read, ready two cycles after mem_sel
    post_req(0, 1'b0, 16'h0040, 32'h0);
    do_txn(2, 32'hDEADBEEF, 1'b0);
    check_eq("read_rdata", bus.rdata, 32'hDEADBEEF);

    // Write from requester 2 leaves rdata alone
    post_req(2, 1'b1, 16'h0100, 32'h12345678);
    do_txn(1, 32'hCAFEF00D, 1'b0);
    check_eq("write_rdata_kept", bus.rdata, 32'hDEADBEEF);

    // Ready on the timeout edge: ack only
    post_rand(1);
    do_txn(int'(TO) - 1, '0, 1'b1);
    check_eq("edge_sticky", err_sticky, 0);

    // Genuine timeout, then the next requester is served
    post_rand(0);
    post_rand(1);
    do_txn(int'(TO) + 5, '0, 1'b1);
    check_eq("to_sticky", err_sticky, 1);
    do_txn(0, '0, 1'b1);
    check_eq("to_next_gid", grant_id, 1);
    check_eq("to_sticky_kept", err_sticky, 1);

    // Randomized traffic
    perturb = 1'b1;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!bus.req_sel[i] && $urandom_range(0, 2) == 0) post_rand(i);
      end
      if (bus.req_sel == '0) begin
        bus.mem_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_eq("rand_idle_sel",  bus.mem_sel, 0);
        check_eq("rand_idle_busy", busy, 0);
        post_rand(int'($urandom_range(0, N - 1)));
      end
      do_txn(rand_lat(), '0, 1'b1);
    end

    // Reset in the middle of requester 1's ISSUE
    perturb       = 1'b0;
    bus.req_sel   = '0;
    bus.mem_ready = 1'b0;
    post_rand(1);
    tick();
    tick();
    tick();
    @(negedge clk);
    check_eq("midrst_pre_sel", bus.mem_sel, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_sel",    bus.mem_sel, 0);
    check_eq("midrst_busy",   busy, 0);
    check_eq("midrst_ackerr", {bus.req_ack, bus.req_err}, 0);
    check_eq("midrst_sticky", err_sticky, 0);
    check_eq("midrst_gid",    grant_id, 0);
    check_eq("midrst_addr",   bus.mem_addr, 0);
    check_eq("midrst_rdata",  bus.rdata, 0);
    m_rr        = 0;
    m_sticky    = 1'b0;
    m_rdata     = '0;
    bus.req_sel = '0;
    repeat (2) begin
      @(negedge clk);
      check_eq("inrst_ackerr", {bus.req_ack, bus.req_err}, 0);
    end
    rst_n = 1'b1;
    post_rand(0);
    post_rand(1);
    do_txn(0, '0, 1'b1);
    check_eq("postrst_first_gid", grant_id, 0);
    do_txn(1, '0, 1'b1);
    check_eq("postrst_second_gid", grant_id, 1);

    // A little more random traffic after reset
    perturb = 1'b1;
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!bus.req_sel[i] && $urandom_range(0, 1) == 0) post_rand(i);
      end
      do_txn(rand_lat(), '0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/nmcu_mem_arbiter.md
NMCU_MEM_ARBITER -- requirements
Module: nmcu_mem_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (NMCUs plus controller port); SHALL be at least 2.
REQ-002 Parameter ADDR_WIDTH, default 16, memory address width.
REQ-003 Parameter DATABUS_WIDTH, default 32, memory data width.
REQ-004 Parameter TIMEOUT, default 64, maximum ISSUE cycles before abort; SHALL be at least 2.
REQ-005 One clock; reset is asynchronous and active-low: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-006 req_sel input [NUM_REQ-1:0], per-requester access request, level, held until that requester's ack or err.
REQ-007 req_w input [NUM_REQ-1:0], 1 = write, 0 = read.
REQ-008 req_addr input [ADDR_WIDTH-1:0] x NUM_REQ (unpacked), request address.
REQ-009 req_wdata input [DATABUS_WIDTH-1:0] x NUM_REQ, write data.
REQ-010 req_ack output [NUM_REQ-1:0], one-cycle completion pulse, one-hot or zero.
REQ-011 req_err output [NUM_REQ-1:0], one-cycle timeout pulse, one-hot or zero.
REQ-012 rdata output [DATABUS_WIDTH-1:0], read data, shared by all requesters, valid while req_ack is high.
REQ-013 mem_sel, mem_w output 1 each; mem_addr output [ADDR_WIDTH-1:0]; mem_wdata output [DATABUS_WIDTH-1:0]; mem_ready input 1; mem_rdata input [DATABUS_WIDTH-1:0]. These form the single shared memory port.
REQ-014 busy output 1, high in any state other than IDLE; grant_id output [$clog2(NUM_REQ)-1:0], current or last winner; err_sticky output 1, set by any timeout.

Function
REQ-015 FSM states: IDLE, ISSUE, RELEASE. All outputs are registered.
REQ-016 IDLE with req_sel != 0 at a clock edge:
- winner = the first set bit scanning upward from rr_ptr, wrapping modulo NUM_REQ;
- latch the winner's addr, w and wdata into mem_addr, mem_w and mem_wdata;
- set grant_id = winner and mem_sel = 1;
- go to ISSUE. mem_sel is therefore visible one cycle after the request is sampled.
REQ-017 IDLE with req_sel == 0: no change; mem_sel stays 0.
REQ-018 In ISSUE, the latched address, data and w SHALL be held stable, ignoring any changes on req_* inputs.
REQ-019 ISSUE with mem_ready == 1 at an edge:
- req_ack[grant_id] = 1 for exactly one cycle;
- rdata = mem_rdata on reads; rdata is unchanged on writes;
- mem_sel = 0, mem_w = 0;
- rr_ptr = (grant_id + 1) mod NUM_REQ;
- go to RELEASE.
REQ-020 The ISSUE timeout counter SHALL clear on entry to ISSUE and increment each ISSUE cycle without mem_ready.
REQ-021 When the counter reaches TIMEOUT-1 without mem_ready:
- req_err[grant_id] = 1 for exactly one cycle;
- err_sticky = 1;
- mem_sel = 0, mem_w = 0;
- rr_ptr advances as in REQ-019;
- go to RELEASE.
If mem_ready arrives on that same edge, ack SHALL take priority and no err is raised.
REQ-022 RELEASE lasts exactly one cycle with mem_sel = 0, then goes to IDLE. This guarantees a one-cycle bus-idle gap between transactions.
REQ-023 A requester SHALL deassert req_sel or present its next request by the edge ending RELEASE. Arbitration samples req_sel only in IDLE.
REQ-024 Minimum transaction = 3 cycles (IDLE sample, ISSUE with immediate ready, RELEASE). Back-to-back grants from continuously held requests rotate round-robin, so no requester is starved.
REQ-025 rr_ptr width is $clog2(NUM_REQ); wrap from NUM_REQ-1 to 0 is explicit modulo. NUM_REQ that is not a power of two SHALL never produce an out-of-range index.
REQ-026 mem_ready outside ISSUE SHALL be ignored.
REQ-027 err_sticky clears only on reset.

Reset
REQ-028 On rst_n low, asynchronously and at any state including mid-ISSUE:
- state = IDLE, rr_ptr = 0, grant_id = 0, timeout counter = 0;
- mem_sel = 0, mem_w = 0, mem_addr = 0, mem_wdata = 0;
- req_ack = 0, req_err = 0, rdata = 0, busy = 0, err_sticky = 0.
An in-flight transaction SHALL be dropped with no ack or err.
REQ-029 After rst_n rises, the first arbitration SHALL start from rr_ptr = 0.

Verification
REQ-030 Single read: req_sel = 0001, addr 0x0040, mem_ready high 2 cycles after mem_sel with mem_rdata 0xDEADBEEF -> mem_addr = 0x0040, mem_w = 0, req_ack = 0001 for one cycle, rdata = 0xDEADBEEF, then mem_sel low for one cycle.
REQ-031 Contention: req_sel = 1111 held, always ready -> grant order 0, 1, 2, 3, 0; each ack separated by 3 cycles.
REQ-032 Write: req 2 with w = 1, addr 0x0100, wdata 0x12345678 -> mem_w = 1 and mem_wdata = 0x12345678 for the whole ISSUE; req_ack = 0100; rdata unchanged.
REQ-033 Timeout: mem_ready held 0, TIMEOUT = 64 -> req_err pulses after 64 ISSUE cycles, err_sticky = 1, next requester is granted, err_sticky stays 1.
REQ-034 Reset mid-ISSUE: rst_n low during req 1's ISSUE -> mem_sel drops immediately with no ack or err; after release, req_sel = 0011 grants 0 first.
REQ-035 Simultaneous edge: mem_ready rises on the same edge the counter hits TIMEOUT-1 -> ack only, err_sticky = 0.
